// File: rtl/sipo_frame_pkg.sv
// Shared definitions for the serial-in/parallel-out frame receiver.
package sipo_frame_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  // Fixed 2-bit state encoding.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STOP  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_STOP  = STOP,
    ST_ABORT = ABORT
  } state_e;

endpackage

// File: rtl/sipo_shift_en.sv
// Enabled shift register: shifts left with the new bit at the LSB.
// Ports: clk, reset (async active-low), shift_en, clear (sync, wins over
// shift_en), serial_in, q (registered parallel contents).
module sipo_shift_en
  import sipo_frame_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame receiver: start bit (0), WIDTH data bits MSB first, stop bit (1).
// Ports: clk, reset (async active-low), enable, serial_in, ready, clear_err;
// data_out/valid hold the last accepted word until consumed, busy is high
// outside IDLE, frame_err pulses on a bad stop bit, overrun is sticky.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             shift_en, sh_clear;
  logic             good_stop, bad_stop;
  logic [WIDTH-1:0] sh_q;

  sipo_shift_en #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .clear     (sh_clear),
    .serial_in (serial_in),
    .q         (sh_q)
  );

  // State and bit counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    sh_clear  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !serial_in) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
          sh_clear  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else begin
          shift_en = 1'b1;
          cnt_nxt  = cnt + CW'(1);
          // Last data bit: counter tops out at WIDTH, never wraps.
          if (cnt == CW'(WIDTH - 1)) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (serial_in) begin
          good_stop = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          bad_stop  = 1'b1;
          state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        // Wait for the line to go idle so a stuck-low line is not a new start.
        if (serial_in) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output word, handshake and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      busy      <= (state_nxt != ST_IDLE);
      frame_err <= bad_stop;
      // A handshake in the same cycle frees the slot for the new word.
      if (good_stop && (!valid || ready)) begin
        data_out <= sh_q;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      // A new overrun event wins over clear_err.
      if (good_stop && valid && !ready) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl with a scoreboard of expected words.
module tb_sipo_frame_ctrl;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             serial_in = 1'b1;
  logic             ready = 1'b0;
  logic             clear_err = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid, busy, frame_err, overrun;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cycles = 0;
  int ferr_cycles = 0;
  int v0, f0;
  logic [WIDTH-1:0] exp_q[$];

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .serial_in (serial_in),
    .ready     (ready),
    .clear_err (clear_err),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard side: every consumed word must match the oldest expected one.
  always @(negedge clk) begin
    if (valid) valid_cycles++;
    if (frame_err) ferr_cycles++;
    if (valid && ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  // Drive one line bit, then sit 1 ns after the edge that sampled it.
  task automatic step(input logic si);
    serial_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop, input logic rdy_stop);
    step(1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) step(w[i]);
    ready = rdy_stop;
    step(stop);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1011 with latency check
    v0 = valid_cycles; f0 = ferr_cycles;
    exp_q.push_back(4'b1011);
    step(1'b0);
    check("start_busy", 32'(busy), 32'd1);
    step(1'b1); step(1'b0); step(1'b1); step(1'b1);
    check("pre_stop_valid", 32'(valid), 32'd0);
    step(1'b1);
    check("lat_valid", 32'(valid), 32'd1);
    check("lat_data", 32'(data_out), 32'hB);
    check("lat_busy", 32'(busy), 32'd0);
    step(1'b1); step(1'b1);
    check("one_valid_cycle", 32'(valid_cycles - v0), 32'd1);
    check("no_ferr", 32'(ferr_cycles - f0), 32'd0);

    // Bad stop bit, stuck-low line, then idle
    v0 = valid_cycles; f0 = ferr_cycles;
    send_frame(4'b1011, 1'b0, 1'b1);
    check("bad_ferr", 32'(frame_err), 32'd1);
    check("bad_valid", 32'(valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    step(1'b0);
    check("ferr_pulse_end", 32'(frame_err), 32'd0);
    step(1'b0);
    check("abort_hold", 32'(busy), 32'd1);
    step(1'b1);
    check("abort_exit", 32'(busy), 32'd0);
    step(1'b1);
    check("bad_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("bad_one_ferr", 32'(ferr_cycles - f0), 32'd1);

    // Overrun with consumer stalled, clear priority, then clear
    ready = 1'b0;
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    step(1'b1);
    send_frame(4'b0110, 1'b1, 1'b0);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_keep_data", 32'(data_out), 32'hB);
    check("ovr_valid", 32'(valid), 32'd1);
    clear_err = 1'b1;
    step(1'b1);
    send_frame(4'b1111, 1'b1, 1'b0);
    check("ovr_priority", 32'(overrun), 32'd1);
    step(1'b1);
    check("ovr_clear", 32'(overrun), 32'd0);
    clear_err = 1'b0;
    check("ovr_old_data", 32'(data_out), 32'hB);
    ready = 1'b1;
    step(1'b1);
    check("drain_valid", 32'(valid), 32'd0);

    // Good stop coinciding with a handshake
    ready = 1'b0;
    exp_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    step(1'b1);
    exp_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 1'b1);
    check("hs_data", 32'(data_out), 32'h6);
    check("hs_valid", 32'(valid), 32'd1);
    check("hs_no_ovr", 32'(overrun), 32'd0);
    step(1'b1);
    check("hs_drained", 32'(valid), 32'd0);

    // Enable dropped mid-frame, then a clean 1111 frame
    v0 = valid_cycles; f0 = ferr_cycles;
    step(1'b0); step(1'b1); step(1'b0);
    enable = 1'b0;
    step(1'b1);
    check("abort_en_busy", 32'(busy), 32'd0);
    step(1'b0);
    check("disabled_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    step(1'b1);
    check("en_abort_no_valid", 32'(valid_cycles - v0), 32'd0);
    exp_q.push_back(4'b1111);
    send_frame(4'b1111, 1'b1, 1'b1);
    check("f1111_data", 32'(data_out), 32'hF);
    check("f1111_valid", 32'(valid), 32'd1);
    step(1'b1);
    check("en_abort_ferr", 32'(ferr_cycles - f0), 32'd0);

    // Async reset mid-SHIFT, then a fresh 0001 frame
    step(1'b0); step(1'b0); step(1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    serial_in = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1);
    exp_q.push_back(4'b0001);
    send_frame(4'b0001, 1'b1, 1'b1);
    check("f0001_data", 32'(data_out), 32'h1);
    check("f0001_valid", 32'(valid), 32'd1);
    step(1'b1); step(1'b1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
